prng_word_collector: RTL and testbench



---
 rtl/prng_pkg.sv | 17 +
 rtl/prng_word_fifo.sv | 66 ++++++
 rtl/prng_word_collector.sv | 118 +++++++++++
 tb/tb_prng_word_collector.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/prng_pkg.sv
// Shared widths, collector FSM encoding and the power-on seed of the upstream PRNG.
package prng_pkg;

  localparam int WORD_W         = 32;
  localparam int BYTE_W         = 8;
  localparam int BYTES_PER_WORD = 4;

  localparam logic [WORD_W-1:0] DEFAULT_SEED = 32'h02468acd;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_CAP  = 2'd3
  } col_state_t;

endpackage

// File: rtl/prng_word_fifo.sv
// Synchronous show-ahead word FIFO with occupancy count; head reads as zero when empty.
// Latency: a write is visible at the head on the following cycle (no write-to-read bypass).
// Backpressure: writes while full are dropped unless a pop lands on the same edge; pops while empty are ignored.
module prng_word_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 32
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     wr_vld,
  input  logic [W-1:0]             wr_dat,
  input  logic                     rd_rdy,
  output logic                     rd_vld,
  output logic [W-1:0]             rd_dat,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          empty;
  logic          full;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CW'(DEPTH));
  assign do_pop  = rd_rdy & ~empty;
  assign do_push = wr_vld & (~full | do_pop);

  assign rd_vld = ~empty;
  assign rd_dat = empty ? '0 : mem[rd_ptr_q];
  assign count  = count_q;

  // Storage carries no reset; the empty mux keeps stale contents off the head.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_q] <= wr_dat;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/prng_word_collector.sv
// Requests 4-byte bursts from prng_top, assembles them LSB-first into words and prefetches into a FIFO.
// Latency: word at the FIFO head 5 cycles after get_random when PRNG_LAT=1 (PRNG_LAT+4 in general).
// Backpressure: rnd_valid/rnd_ready pop; a new burst is only requested when a FIFO slot is reserved for it.
module prng_word_collector
  import prng_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int PRNG_LAT   = 1
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic                          en,
  output logic                          get_random,
  input  logic [BYTE_W-1:0]             prng_data,
  output logic [WORD_W-1:0]             rnd_word,
  output logic                          rnd_valid,
  input  logic                          rnd_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fill_level
);

  localparam int CNT_W     = $clog2(FIFO_DEPTH) + 1;
  localparam int SUM_W     = CNT_W + 1;
  localparam int BCW       = $clog2(BYTES_PER_WORD);
  localparam int WCW       = (PRNG_LAT > 2) ? $clog2(PRNG_LAT) : 1;
  localparam int WAIT_LOAD = (PRNG_LAT > 1) ? PRNG_LAT - 2 : 0;

  localparam logic [BCW-1:0] LAST_BYTE = BCW'(BYTES_PER_WORD - 1);

  col_state_t        state_q;
  col_state_t        state_nxt;
  logic [BCW-1:0]    byte_cnt_q;
  logic [WCW-1:0]    wait_cnt_q;
  logic [WORD_W-1:0] asm_q;
  logic [WORD_W-1:0] asm_nxt;
  logic              armed_q;
  logic              push_vld;
  logic              pop_rdy;
  logic [SUM_W-1:0]  room_sum;
  logic              room;

  assign pop_rdy  = rnd_valid & rnd_ready;
  assign push_vld = (state_q == ST_CAP) && (byte_cnt_q == LAST_BYTE);

  // Occupancy after this edge's push/pop, plus one slot reserved for the burst about to be requested.
  assign room_sum = SUM_W'(fill_level) + SUM_W'(push_vld) + SUM_W'(1) - SUM_W'(pop_rdy);
  assign room     = (room_sum <= SUM_W'(FIFO_DEPTH));

  // The last byte goes straight into the pushed word so the push happens on the capture edge itself.
  always_comb begin
    asm_nxt = asm_q;
    asm_nxt[int'(byte_cnt_q) * BYTE_W +: BYTE_W] = prng_data;
  end

  always_comb begin
    state_nxt = state_q;
    case (state_q)
      ST_IDLE: begin
        if (armed_q && en && room) begin
          state_nxt = ST_REQ;
        end
      end
      ST_REQ: begin
        state_nxt = (PRNG_LAT > 1) ? ST_WAIT : ST_CAP;
      end
      ST_WAIT: begin
        if (wait_cnt_q == '0) begin
          state_nxt = ST_CAP;
        end
      end
      ST_CAP: begin
        if (byte_cnt_q == LAST_BYTE) begin
          state_nxt = (en && room) ? ST_REQ : ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // armed_q holds the FSM in IDLE for the first edge after reset release.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= ST_IDLE;
      get_random <= 1'b0;
      armed_q    <= 1'b0;
      byte_cnt_q <= '0;
      wait_cnt_q <= '0;
      asm_q      <= '0;
    end else begin
      state_q    <= state_nxt;
      get_random <= (state_nxt == ST_REQ);
      armed_q    <= 1'b1;
      if (state_q == ST_REQ) begin
        wait_cnt_q <= WCW'(WAIT_LOAD);
      end else if ((state_q == ST_WAIT) && (wait_cnt_q != '0)) begin
        wait_cnt_q <= wait_cnt_q - 1'b1;
      end
      if (state_q == ST_CAP) begin
        asm_q      <= asm_nxt;
        byte_cnt_q <= byte_cnt_q + 1'b1;
      end
    end
  end

  prng_word_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (WORD_W)
  ) u_fifo (
    .clk    (clk),
    .rstn   (rstn),
    .wr_vld (push_vld),
    .wr_dat (asm_nxt),
    .rd_rdy (rnd_ready),
    .rd_vld (rnd_valid),
    .rd_dat (rnd_word),
    .count  (fill_level)
  );

endmodule

// File: tb/tb_prng_word_collector.sv
// Directed bench: behavioural prng_top model, word scoreboard, cycle table for prefetch/draw/en-drop, reset-mid-burst sequence.
module tb_prng_word_collector;
  import prng_pkg::*;

  logic        clk = 1'b0;
  logic        rstn;
  logic        en;
  logic        get_random;
  logic [7:0]  prng_data = 8'h00;
  logic [31:0] rnd_word;
  logic        rnd_valid;
  logic        rnd_ready;
  logic [2:0]  fill_level;

  always #5 clk = ~clk;

  prng_word_collector #(
    .FIFO_DEPTH (4),
    .PRNG_LAT   (1)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .en         (en),
    .get_random (get_random),
    .prng_data  (prng_data),
    .rnd_word   (rnd_word),
    .rnd_valid  (rnd_valid),
    .rnd_ready  (rnd_ready),
    .fill_level (fill_level)
  );

  int          tests   = 0;
  int          fails   = 0;
  int          cyc     = 0;
  int          gr_cnt  = 0;
  int          prev_gr = -1;
  int          idx     = 4;
  logic [31:0] mseed   = DEFAULT_SEED;
  logic [31:0] cur     = 32'h0;
  logic [31:0] exp_q[$];

  typedef struct {
    logic        en;
    logic        rdy;
    int          n;
    logic        gr;
    int          fill;
    logic        vld;
    logic        chk_word;
    logic [31:0] word;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [31:0] lcg(input logic [31:0] s);
    return s * 32'h0019660d + 32'h3c6ef35f;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // prng_top model: byte k of the burst is driven during cycle C(1+k) after the request cycle C0.
  always @(negedge clk) begin
    if (!rstn) begin
      mseed     = DEFAULT_SEED;
      idx       = 4;
      prev_gr   = -1;
      prng_data = 8'h00;
      exp_q.delete();
    end else begin
      if (idx < 4) begin
        prng_data = cur[8*idx +: 8];
        idx++;
      end
      if (rnd_valid && rnd_ready) begin
        if (exp_q.size() == 0) check("sb_underflow", 32'd1, 32'd0);
        else check("sb_order", rnd_word, exp_q.pop_front());
      end
      if (get_random) begin
        gr_cnt++;
        if (prev_gr >= 0) check("gr_spacing_ge5", 32'(cyc - prev_gr >= 5), 32'd1);
        prev_gr = cyc;
        cur     = mseed;
        mseed   = lcg(mseed);
        exp_q.push_back(cur);
        idx     = 0;
      end
    end
  end

  initial begin
    int   n;
    int   edges;
    int   lat;
    logic found;

    rstn      = 1'b0;
    en        = 1'b0;
    rnd_ready = 1'b0;

    //                en    rdy   n   gr    fill vld   chk   word
    vecs.push_back('{1'b1, 1'b0,  1, 1'b0, 0, 1'b0, 1'b0, 32'h0});
    vecs.push_back('{1'b1, 1'b0,  2, 1'b1, 0, 1'b0, 1'b0, 32'h0});
    vecs.push_back('{1'b1, 1'b0,  3, 1'b0, 0, 1'b0, 1'b0, 32'h0});
    vecs.push_back('{1'b1, 1'b0,  6, 1'b0, 0, 1'b0, 1'b1, 32'h0});
    vecs.push_back('{1'b1, 1'b0,  7, 1'b1, 1, 1'b1, 1'b1, DEFAULT_SEED});
    vecs.push_back('{1'b1, 1'b0, 12, 1'b1, 2, 1'b1, 1'b1, DEFAULT_SEED});
    vecs.push_back('{1'b1, 1'b0, 17, 1'b1, 3, 1'b1, 1'b0, 32'h0});
    vecs.push_back('{1'b1, 1'b0, 22, 1'b0, 4, 1'b1, 1'b0, 32'h0});
    vecs.push_back('{1'b1, 1'b0, 27, 1'b0, 4, 1'b1, 1'b0, 32'h0});
    vecs.push_back('{1'b1, 1'b0, 40, 1'b0, 4, 1'b1, 1'b1, DEFAULT_SEED});
    vecs.push_back('{1'b1, 1'b1, 41, 1'b1, 3, 1'b1, 1'b1, lcg(DEFAULT_SEED)});
    vecs.push_back('{1'b1, 1'b0, 42, 1'b0, 3, 1'b1, 1'b0, 32'h0});
    vecs.push_back('{1'b1, 1'b0, 45, 1'b0, 3, 1'b1, 1'b0, 32'h0});
    vecs.push_back('{1'b1, 1'b0, 46, 1'b0, 4, 1'b1, 1'b0, 32'h0});
    vecs.push_back('{1'b1, 1'b0, 50, 1'b0, 4, 1'b1, 1'b0, 32'h0});
    vecs.push_back('{1'b1, 1'b1, 51, 1'b1, 3, 1'b1, 1'b0, 32'h0});
    vecs.push_back('{1'b1, 1'b1, 52, 1'b0, 2, 1'b1, 1'b0, 32'h0});
    vecs.push_back('{1'b1, 1'b1, 53, 1'b0, 1, 1'b1, 1'b0, 32'h0});
    vecs.push_back('{1'b1, 1'b0, 54, 1'b0, 1, 1'b1, 1'b0, 32'h0});
    vecs.push_back('{1'b1, 1'b0, 55, 1'b0, 1, 1'b1, 1'b0, 32'h0});
    vecs.push_back('{1'b1, 1'b1, 56, 1'b1, 1, 1'b1, 1'b0, 32'h0});
    vecs.push_back('{1'b1, 1'b1, 57, 1'b0, 0, 1'b0, 1'b1, 32'h0});
    vecs.push_back('{1'b1, 1'b1, 61, 1'b1, 1, 1'b1, 1'b0, 32'h0});
    vecs.push_back('{1'b1, 1'b1, 62, 1'b0, 0, 1'b0, 1'b0, 32'h0});
    vecs.push_back('{1'b0, 1'b0, 64, 1'b0, 0, 1'b0, 1'b0, 32'h0});
    vecs.push_back('{1'b0, 1'b0, 66, 1'b0, 1, 1'b1, 1'b0, 32'h0});
    vecs.push_back('{1'b0, 1'b0, 80, 1'b0, 1, 1'b1, 1'b0, 32'h0});

    repeat (3) @(posedge clk);
    #1;
    check("rst_get_random", 32'(get_random), 32'd0);
    check("rst_rnd_valid",  32'(rnd_valid),  32'd0);
    check("rst_rnd_word",   rnd_word,        32'd0);
    check("rst_fill_level", 32'(fill_level), 32'd0);

    // Cycle n is observed 1 time unit after the n-th posedge following reset release.
    rstn = 1'b1;
    n    = 0;
    foreach (vecs[i]) begin
      en        = vecs[i].en;
      rnd_ready = vecs[i].rdy;
      while (n < vecs[i].n) begin
        @(posedge clk);
        #1;
        n++;
      end
      check($sformatf("c%0d_get_random", n), 32'(get_random), 32'(vecs[i].gr));
      check($sformatf("c%0d_fill_level", n), 32'(fill_level), 32'(vecs[i].fill));
      check($sformatf("c%0d_rnd_valid",  n), 32'(rnd_valid),  32'(vecs[i].vld));
      if (vecs[i].chk_word) check($sformatf("c%0d_rnd_word", n), rnd_word, vecs[i].word);
    end
    check("request_total", 32'(gr_cnt), 32'd8);

    // Reset asserted while the collector is capturing byte 2 of a burst.
    en    = 1'b1;
    found = 1'b0;
    for (int k = 0; k < 10 && !found; k++) begin
      @(posedge clk);
      #1;
      found = get_random;
    end
    check("mid_req_seen", 32'(found), 32'd1);
    repeat (3) @(posedge clk);
    #1;
    rstn = 1'b0;
    #1;
    check("mid_rst_get_random", 32'(get_random), 32'd0);
    check("mid_rst_rnd_valid",  32'(rnd_valid),  32'd0);
    check("mid_rst_rnd_word",   rnd_word,        32'd0);
    check("mid_rst_fill_level", 32'(fill_level), 32'd0);
    @(posedge clk);
    #1;
    rstn = 1'b1;

    @(posedge clk);
    #1;
    check("rel_edge1_get_random", 32'(get_random), 32'd0);
    edges = 1;
    found = 1'b0;
    while (!found && edges < 10) begin
      @(posedge clk);
      #1;
      edges++;
      found = get_random;
    end
    check("rel_req_seen",    32'(found),      32'd1);
    check("rel_req_not_early", 32'(edges >= 2), 32'd1);

    lat   = 0;
    found = 1'b0;
    while (!found && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
      found = rnd_valid;
    end
    check("rel_valid_latency", 32'(lat), 32'd5);
    check("rel_first_word",    rnd_word, DEFAULT_SEED);

    en        = 1'b0;
    rnd_ready = 1'b1;
    @(posedge clk);
    #1;
    rnd_ready = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("end_get_random", 32'(get_random), 32'd0);
    check("end_fill_level", 32'(fill_level), 32'd1);
    check("end_rnd_word",   rnd_word,        lcg(DEFAULT_SEED));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
